mult_job_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares one `signed_multiplier` datapath between several requesters. It accepts operand pairs on a per-requester req/done handshake, grants one requester at a time, and drives the datapath's `load`/`psel`/`reg_en`/`shift_en` strobes through the add/shift iterations until `zflag` or the iteration cap. It returns the registered product and sign with a one-cycle `done` pulse. It sits between the input sources (switch bank, host/test port) and the datapath, in place of the single-source control unit.

---
 rtl/mult_pkg.sv | 24 ++
 rtl/mult_job_scheduler_rr_arbiter.sv | 32 +++
 rtl/mult_job_scheduler.sv | 153 +++++++++++++++
 tb/tb_mult_job_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the multiplier job scheduler: FSM states, strobe bundle, default width.
// No logic; package only.
// Imported by the scheduler top and testbench.
package mult_pkg;

   localparam int MULT_WIDTH = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_SHIFT,
      S_DONE
   } sched_state_t;

   // Control strobes into the shared signed_multiplier datapath.
   typedef struct packed {
      logic load;
      logic psel;
      logic reg_en;
      logic shift_en;
   } strobe_t;

endpackage

// File: rtl/mult_job_scheduler_rr_arbiter.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
   parameter int N_REQ = 2,
   localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    rr_ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    gnt_idx,
   output logic             any
);

   // Scan N_REQ positions starting at rr_ptr; the first set request wins.
   always_comb begin
      int cand;
      cand    = 0;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = (int'(rr_ptr) + off) % N_REQ;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/mult_job_scheduler.sv
// Shares one shift-add signed multiplier between N_REQ requesters with round-robin grant.
// Latency: done pulses 3+2k cycles after the grant edge (k = bit length of |a|), capped at 2+2*MAX_ITER.
// Backpressure: one job at a time; requesters hold req until their done bit, others wait in IDLE.
module mult_job_scheduler
   import mult_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int WIDTH    = MULT_WIDTH,
   parameter int MAX_ITER = WIDTH,
   localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int PW      = 2 * WIDTH - 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   op_a,
   input  logic [N_REQ*WIDTH-1:0]   op_b,
   output logic                     busy,
   output logic [IW-1:0]            gnt_id,
   output logic [N_REQ-1:0]         done,
   output logic [PW-1:0]            result,
   output logic                     result_sign,
   output logic [WIDTH-1:0]         mul_multiplier,
   output logic [WIDTH-1:0]         mul_multiplicand,
   output logic                     mul_load,
   output logic                     mul_psel,
   output logic                     mul_reg_en,
   output logic                     mul_shift_en,
   input  logic                     mul_zflag,
   input  logic [PW-1:0]            mul_product,
   input  logic                     mul_sign
);

   localparam int CW = $clog2(MAX_ITER + 1);

   sched_state_t     state, state_nxt;
   strobe_t          stb;
   logic [IW-1:0]    rr_ptr;
   logic [CW-1:0]    iter;
   logic [N_REQ-1:0] arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_any;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [PW-1:0]    result_q;
   logic             result_sign_q;
   logic             last_iter;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   assign last_iter = (int'(iter) + 1 == MAX_ITER);

   // One-hot mux of the granted requester's operand pair.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_a = op_a[i*WIDTH +: WIDTH];
            sel_b = op_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and datapath strobes; the final zflag check is skipped when the cap is hit.
   always_comb begin
      state_nxt = state;
      stb       = '0;
      case (state)
         S_IDLE:  if (arb_any) state_nxt = S_LOAD;
         S_LOAD: begin
            stb.load   = 1'b1;
            stb.reg_en = 1'b1;
            state_nxt  = S_ADD;
         end
         S_ADD: begin
            if (mul_zflag) begin
               state_nxt = S_DONE;
            end else begin
               stb.psel   = 1'b1;
               stb.reg_en = 1'b1;
               state_nxt  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            stb.shift_en = 1'b1;
            state_nxt    = last_iter ? S_DONE : S_ADD;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant capture, iteration counter, result capture and round-robin pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr           <= '0;
         iter             <= '0;
         gnt_id           <= '0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
         result_q         <= '0;
         result_sign_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (arb_any) begin
                  gnt_id           <= arb_idx;
                  mul_multiplier   <= sel_a;
                  mul_multiplicand <= sel_b;
               end
            end
            S_LOAD:  iter <= '0;
            S_SHIFT: iter <= iter + 1'b1;
            S_DONE: begin
               result_q      <= mul_product;
               result_sign_q <= mul_sign;
               rr_ptr        <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Completion pulse to the granted requester only.
   always_comb begin
      done = '0;
      if (state == S_DONE) done[gnt_id] = 1'b1;
   end

   // During DONE the datapath product is already final, so it is passed straight through;
   // that makes result valid in the same cycle as done and held by result_q afterwards.
   assign result      = (state == S_DONE) ? mul_product : result_q;
   assign result_sign = (state == S_DONE) ? mul_sign    : result_sign_q;

   assign busy         = (state != S_IDLE);
   assign mul_load     = stb.load;
   assign mul_psel     = stb.psel;
   assign mul_reg_en   = stb.reg_en;
   assign mul_shift_en = stb.shift_en;

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Scoreboard bench for mult_job_scheduler with a behavioural shift-add datapath.
// Stimulus pushes hand-computed expectations; a negedge monitor pops them on each done pulse.
// Bounded waits everywhere; summary line at the end.
module tb_mult_job_scheduler;
   import mult_pkg::*;

   localparam int N_REQ = 2;
   localparam int W     = 8;
   localparam int PW    = 2 * W - 1;

   logic               clk, rst;
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] op_a, op_b;
   logic               busy;
   logic [0:0]         gnt_id;
   logic [N_REQ-1:0]   done;
   logic [PW-1:0]      result;
   logic               result_sign;
   logic [W-1:0]       mul_multiplier, mul_multiplicand;
   logic               mul_load, mul_psel, mul_reg_en, mul_shift_en;
   logic               mul_zflag;
   logic [PW-1:0]      mul_product;
   logic               mul_sign;

   mult_job_scheduler #(.N_REQ(N_REQ), .WIDTH(W), .MAX_ITER(W)) dut (
      .clk              (clk),
      .rst              (rst),
      .req              (req),
      .op_a             (op_a),
      .op_b             (op_b),
      .busy             (busy),
      .gnt_id           (gnt_id),
      .done             (done),
      .result           (result),
      .result_sign      (result_sign),
      .mul_multiplier   (mul_multiplier),
      .mul_multiplicand (mul_multiplicand),
      .mul_load         (mul_load),
      .mul_psel         (mul_psel),
      .mul_reg_en       (mul_reg_en),
      .mul_shift_en     (mul_shift_en),
      .mul_zflag        (mul_zflag),
      .mul_product      (mul_product),
      .mul_sign         (mul_sign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural signed_multiplier: magnitudes, add multiplicand when multiplier lsb is 1, shift.
   logic [W-1:0]  dp_mreg;
   logic [PW-1:0] dp_acc, dp_mcand;
   logic          dp_sign;

   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      return v[W-1] ? (~v + 1'b1) : v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         dp_mreg  <= '0;
         dp_acc   <= '0;
         dp_mcand <= '0;
         dp_sign  <= 1'b0;
      end else if (mul_load) begin
         dp_mreg  <= mag(mul_multiplier);
         dp_mcand <= PW'(mag(mul_multiplicand));
         dp_acc   <= '0;
         dp_sign  <= mul_multiplier[W-1] ^ mul_multiplicand[W-1];
      end else begin
         if (mul_psel && mul_reg_en && dp_mreg[0]) dp_acc <= dp_acc + dp_mcand;
         if (mul_shift_en) begin
            dp_mreg  <= dp_mreg >> 1;
            dp_mcand <= dp_mcand << 1;
         end
      end
   end

   assign mul_zflag   = (dp_mreg == '0);
   assign mul_product = dp_acc;
   assign mul_sign    = dp_sign;

   typedef struct {
      int   id;
      int   res;
      logic sgn;
      int   cyc;
      int   adds;
      int   shifts;
   } exp_t;

   exp_t sb[$];
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic expect_job(input int id, input int res, input logic sgn, input int c,
                             input int adds, input int shifts);
      exp_t e;
      e = '{id, res, sgn, c, adds, shifts};
      sb.push_back(e);
   endtask

   task automatic start_job(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[idx*W +: W] = a;
      op_b[idx*W +: W] = b;
      req[idx]         = 1'b1;
   endtask

   task automatic wait_done(input int idx);
      int n;
      n = 0;
      while (done[idx] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (done[idx] !== 1'b1) check("wait_done_timeout", 32'(done), 32'(1 << idx));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},   32'(busy), 0);
      check({tag, "_gnt_id"}, 32'(gnt_id), 0);
      check({tag, "_done"},   32'(done), 0);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_sign"},   32'(result_sign), 0);
      check({tag, "_mul_a"},  32'(mul_multiplier), 0);
      check({tag, "_mul_b"},  32'(mul_multiplicand), 0);
      check({tag, "_strobes"}, 32'({mul_load, mul_psel, mul_reg_en, mul_shift_en}), 0);
   endtask

   // Monitor: count strobes per job, check every done pulse against the scoreboard head.
   initial begin : monitor
      int   n_load, n_add, n_sh;
      bit   hold_chk;
      int   hold_res;
      logic hold_sgn;
      exp_t e;
      n_load = 0; n_add = 0; n_sh = 0;
      hold_chk = 1'b0; hold_res = 0; hold_sgn = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            n_load = 0; n_add = 0; n_sh = 0;
            hold_chk = 1'b0;
         end else begin
            if (hold_chk) begin
               check("result_hold", 32'(result), 32'(hold_res));
               check("sign_hold", 32'(result_sign), 32'(hold_sgn));
               hold_chk = 1'b0;
            end
            if (mul_load) n_load++;
            if (mul_psel && mul_reg_en) n_add++;
            if (mul_shift_en) n_sh++;
            if (done != '0) begin
               check("done_onehot", 32'($onehot(done)), 1);
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'(done), 0);
               end else begin
                  e = sb.pop_front();
                  check("done_id", 32'(done), 32'(1 << e.id));
                  check("gnt_id", 32'(gnt_id), 32'(e.id));
                  check("result", 32'(result), 32'(e.res));
                  check("result_sign", 32'(result_sign), 32'(e.sgn));
                  check("done_cycle", 32'(cyc), 32'(e.cyc));
                  check("load_count", 32'(n_load), 1);
                  check("add_count", 32'(n_add), 32'(e.adds));
                  check("shift_count", 32'(n_sh), 32'(e.shifts));
                  hold_chk = 1'b1;
                  hold_res = e.res;
                  hold_sgn = e.sgn;
               end
               n_load = 0; n_add = 0; n_sh = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Stimulus: each job starts at a negedge; cyc at that point is "cycle 0".
   initial begin : stim
      int start;
      rst  = 1'b1;
      req  = '0;
      op_a = '0;
      op_b = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // 3 * -5 = -15 on requester 0: k=2, done in cycle 7.
      start = cyc;
      expect_job(0, 15, 1'b1, start + 7, 2, 2);
      start_job(0, 8'd3, 8'hFB);
      wait_done(0);
      req[0] = 1'b0;
      @(negedge clk);

      // Zero multiplier: straight from ADD to DONE, no add strobes.
      start = cyc;
      expect_job(0, 0, 1'b0, start + 3, 0, 0);
      start_job(0, 8'd0, 8'd77);
      wait_done(0);
      req[0] = 1'b0;
      @(negedge clk);

      // -128 * 127 hits the 8-iteration cap: done in cycle 18.
      start = cyc;
      expect_job(0, 16256, 1'b1, start + 18, 8, 8);
      start_job(0, 8'h80, 8'd127);
      wait_done(0);
      req[0] = 1'b0;
      @(negedge clk);

      // Requester 1: 5 * -6, operands changed and req dropped during ADD.
      start = cyc;
      expect_job(1, 30, 1'b1, start + 9, 3, 3);
      start_job(1, 8'd5, 8'hFA);
      repeat (2) @(negedge clk);
      check("busy_mid_job", 32'(busy), 1);
      op_a[W +: W] = 8'd7;
      op_b[W +: W] = 8'd7;
      req[1]       = 1'b0;
      wait_done(1);
      @(negedge clk);

      // Both held: grants alternate 0,1,0,1 with 8-cycle job spacing.
      start = cyc;
      expect_job(0, 4, 1'b0, start + 7,  2, 2);
      expect_job(1, 9, 1'b0, start + 15, 2, 2);
      expect_job(0, 4, 1'b0, start + 23, 2, 2);
      expect_job(1, 9, 1'b0, start + 31, 2, 2);
      start_job(0, 8'd2, 8'd2);
      start_job(1, 8'd3, 8'd3);
      repeat (31) @(negedge clk);
      req = '0;
      @(negedge clk);

      // Requester 0 job leaves the round-robin pointer at 1.
      start = cyc;
      expect_job(0, 1, 1'b0, start + 5, 1, 1);
      start_job(0, 8'd1, 8'd1);
      wait_done(0);
      req[0] = 1'b0;
      @(negedge clk);

      // Reset during SHIFT of a requester 1 job: everything clears, no done.
      start_job(1, 8'd3, 8'd3);
      repeat (3) @(negedge clk);
      check("in_shift_before_rst", 32'(mul_shift_en), 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid_job_rst");
      rst    = 1'b0;
      req[1] = 1'b0;
      @(negedge clk);

      // After reset the pointer is 0 again, so requester 0 wins the tie.
      start = cyc;
      expect_job(0, 6, 1'b1, start + 7,  2, 2);
      expect_job(1, 1, 1'b0, start + 13, 1, 1);
      start_job(0, 8'd2, 8'hFD);
      start_job(1, 8'hFF, 8'hFF);
      wait_done(0);
      req[0] = 1'b0;
      wait_done(1);
      req[1] = 1'b0;

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
